// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard sequencer for the 5-stage MIPS pipeline.
// Drives IF/ID and ID/EX stall/flush controls and the PC redirect strobe
// for branch mispredict recovery, load-use interlock and halt drain.
// Optional feature macro: PIPE_PERF_COUNTERS_EN adds saturating
// stall_count / flush_count outputs.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_branch_en,
    input  logic                  ex_branch_taken,
    input  logic                  ex_pred_taken,
    input  logic                  ex_halt_en,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  resume,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  redirect_en,
    output logic                  halted,
    output logic [2:0]            state_o
`ifdef PIPE_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
            $error("FLUSH_CYCLES must be in 1..15");
        end
        if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
            $error("DRAIN_CYCLES must be in 1..15");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        LOAD_STALL = 3'd1,
        FLUSH      = 3'd2,
        DRAIN      = 3'd3,
        HALTED     = 3'd4
    } state_t;

    // The first flush cycle happens in RUN/LOAD_STALL, so FLUSH covers the rest.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       mispredict, load_use;
    logic       stall_evt, flush_evt;

    assign mispredict = ex_branch_en & (ex_branch_taken != ex_pred_taken);
    assign load_use   = ex_mem_read & (ex_rt != '0) & id_valid &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign state_o    = state;

    // State and recovery counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and control outputs; everything is held low while in reset.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        redirect_en = 1'b0;
        halted      = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (reset) begin
            case (state)
                RUN, LOAD_STALL: begin
                    if (mispredict) begin
                        redirect_en = 1'b1;
                        flush_id    = 1'b1;
                        flush_ex    = 1'b1;
                        flush_evt   = 1'b1;
                        if (FLUSH_CYCLES == 1) begin
                            state_n = RUN;
                        end else begin
                            state_n = FLUSH;
                            cnt_n   = FLUSH_INIT;
                        end
                    end else if (ex_halt_en) begin
                        stall_if = 1'b1;
                        flush_id = 1'b1;
                        state_n  = DRAIN;
                        cnt_n    = DRAIN_INIT;
                    end else if (state == RUN && load_use) begin
                        // The load has not advanced yet in RUN; in LOAD_STALL it has.
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        flush_ex  = 1'b1;
                        stall_evt = 1'b1;
                        state_n   = LOAD_STALL;
                    end else begin
                        state_n = RUN;
                    end
                end
                FLUSH: begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    if (cnt <= 4'd1) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                DRAIN: begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    if (cnt <= 4'd1) begin
                        state_n = HALTED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                HALTED: begin
                    halted   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    if (resume) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_COUNTERS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating event counters for load-use stalls and honoured mispredicts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_evt) stall_count <= sat_inc(stall_count);
            if (flush_evt) flush_count <= sat_inc(flush_count);
        end
    end
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: single-cycle vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int RW = 5;
    localparam int FC = 2;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_branch_en, ex_branch_taken, ex_pred_taken, ex_halt_en, ex_mem_read;
    logic [RW-1:0] ex_rt, id_rs, id_rt;
    logic          id_valid, id_uses_rt, resume;
    logic          stall_if, stall_id, flush_id, flush_ex, redirect_en, halted;
    logic [2:0]    state_o;
`ifdef PIPE_PERF_COUNTERS_EN
    logic [3:0]    stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .DRAIN_CYCLES(DC), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_branch_en(ex_branch_en), .ex_branch_taken(ex_branch_taken),
        .ex_pred_taken(ex_pred_taken), .ex_halt_en(ex_halt_en),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .resume(resume),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .flush_ex(flush_ex), .redirect_en(redirect_en), .halted(halted),
        .state_o(state_o)
`ifdef PIPE_PERF_COUNTERS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {stall_if, stall_id, flush_id, flush_ex, redirect_en}
    function automatic logic [4:0] outs();
        return {stall_if, stall_id, flush_id, flush_ex, redirect_en};
    endfunction

    task automatic idle_in();
        ex_branch_en = 0; ex_branch_taken = 0; ex_pred_taken = 0; ex_halt_en = 0;
        ex_mem_read = 0; ex_rt = '0; id_valid = 0; id_rs = '0; id_rt = '0;
        id_uses_rt = 0; resume = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: remaining cycles of each recovery window.
    int m_flush_left, m_drain_left;
    bit m_halted, m_bubble;

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_flush_left = 0; m_drain_left = 0; m_halted = 0; m_bubble = 0;
    endtask

    task automatic model_step(output logic [4:0] eo, output logic eh, output logic [2:0] es);
        bit mp, lu, bubble_next;
        mp = ex_branch_en && (ex_branch_taken != ex_pred_taken);
        lu = ex_mem_read && (ex_rt != 0) && id_valid &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        eo = 5'b0; eh = 1'b0; bubble_next = 0;
        if (m_halted) begin
            es = 3'd4; eh = 1'b1; eo = 5'b11000;
            if (resume) m_halted = 0;
        end else if (m_flush_left > 0) begin
            es = 3'd2; eo = 5'b00110;
            m_flush_left--;
        end else if (m_drain_left > 0) begin
            es = 3'd3; eo = 5'b10110;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
        end else begin
            es = m_bubble ? 3'd1 : 3'd0;
            if (mp) begin
                eo = 5'b00111; m_flush_left = FC - 1;
            end else if (ex_halt_en) begin
                eo = 5'b10100; m_drain_left = DC;
            end else if (lu && !m_bubble) begin
                eo = 5'b11010; bubble_next = 1;
            end
        end
        m_bubble = bubble_next;
    endtask

    typedef struct {
        logic          br, tk, pr, hl, mr;
        logic [RW-1:0] ert;
        logic          vld;
        logic [RW-1:0] rs, rt;
        logic          urt;
        logic [4:0]    exp_o;
        logic [2:0]    exp_ns;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [4:0] eo;
        logic       eh;
        logic [2:0] es;

        //        br tk pr hl mr ert vld rs rt urt   exp_o     ns
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3'd0};
        vt[1]  = '{0, 0, 0, 0, 1, 5, 1, 5, 2, 0, 5'b11010, 3'd1};
        vt[2]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 5'b00000, 3'd0};
        vt[3]  = '{0, 0, 0, 0, 1, 7, 1, 3, 7, 1, 5'b11010, 3'd1};
        vt[4]  = '{0, 0, 0, 0, 1, 7, 1, 3, 7, 0, 5'b00000, 3'd0};
        vt[5]  = '{0, 0, 0, 0, 1, 5, 0, 5, 5, 1, 5'b00000, 3'd0};
        vt[6]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 3'd2};
        vt[7]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3'd0};
        vt[8]  = '{1, 0, 1, 0, 1, 4, 1, 4, 0, 0, 5'b00111, 3'd2};
        vt[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b10100, 3'd3};
        vt[10] = '{0, 0, 0, 1, 1, 6, 1, 6, 0, 0, 5'b10100, 3'd3};
        vt[11] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00111, 3'd2};
        vt[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3'd0};

        idle_in();
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_state", 32'(state_o), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_state", 32'(state_o), 32'd0);
        chk("idle_halted", 32'(halted), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            ex_branch_en = vt[i].br; ex_branch_taken = vt[i].tk; ex_pred_taken = vt[i].pr;
            ex_halt_en = vt[i].hl; ex_mem_read = vt[i].mr; ex_rt = vt[i].ert;
            id_valid = vt[i].vld; id_rs = vt[i].rs; id_rt = vt[i].rt; id_uses_rt = vt[i].urt;
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp_o));
            tick();
            chk($sformatf("vec%0d_next", i), 32'(state_o), 32'(vt[i].exp_ns));
            idle_in();
        end

        // Load-use held two cycles, then ex_rt=0 never stalls.
        do_reset();
        ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_valid = 1;
        #1;
        chk("lu_c0_outs", 32'(outs()), 32'b11010);
        chk("lu_c0_state", 32'(state_o), 32'd0);
        tick();
        chk("lu_c1_state", 32'(state_o), 32'd1);
        chk("lu_c1_outs", 32'(outs()), 32'b0);
        idle_in();
        tick();
        chk("lu_c2_state", 32'(state_o), 32'd0);
        ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_valid = 1;
        #1;
        chk("lu_r0_outs", 32'(outs()), 32'b0);
        idle_in();

        // Mispredict with simultaneous load-use; wrong-path mispredict in FLUSH ignored.
        do_reset();
        ex_branch_en = 1; ex_branch_taken = 1; ex_pred_taken = 0;
        ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_valid = 1;
        #1;
        chk("mp_c0_outs", 32'(outs()), 32'b00111);
        tick();
        chk("mp_c1_outs", 32'(outs()), 32'b00110);
        chk("mp_c1_state", 32'(state_o), 32'd2);
        idle_in();
        tick();
        chk("mp_c2_outs", 32'(outs()), 32'b0);
        chk("mp_c2_state", 32'(state_o), 32'd0);

        // Halt drain with a mispredict and a resume injected during DRAIN.
        do_reset();
        ex_halt_en = 1;
        #1;
        chk("h_c0_outs", 32'(outs()), 32'b10100);
        tick();
        idle_in();
        chk("h_c1_state", 32'(state_o), 32'd3);
        chk("h_c1_outs", 32'(outs()), 32'b10110);
        tick();
        ex_branch_en = 1; ex_branch_taken = 0; ex_pred_taken = 1; resume = 1;
        #1;
        chk("h_c2_redirect", 32'(redirect_en), 32'd0);
        chk("h_c2_state", 32'(state_o), 32'd3);
        tick();
        idle_in();
        chk("h_c3_state", 32'(state_o), 32'd3);
        tick();
        chk("h_c4_halted", 32'(halted), 32'd1);
        chk("h_c4_state", 32'(state_o), 32'd4);
        chk("h_c4_outs", 32'(outs()), 32'b11000);
        tick();
        chk("h_c5_halted", 32'(halted), 32'd1);
        resume = 1;
        tick();
        resume = 0;
        chk("h_resume_halted", 32'(halted), 32'd0);
        chk("h_resume_state", 32'(state_o), 32'd0);

        // Asynchronous reset in the middle of DRAIN.
        do_reset();
        ex_halt_en = 1;
        tick();
        idle_in();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs()), 32'b0);
        chk("rst_mid_state", 32'(state_o), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_mid_after", 32'(state_o), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ex_branch_en    = ($urandom % 4) == 0;
            ex_branch_taken = $urandom % 2;
            ex_pred_taken   = $urandom % 2;
            ex_halt_en      = ($urandom % 30) == 0;
            ex_mem_read     = ($urandom % 3) == 0;
            ex_rt           = RW'($urandom % 4);
            id_valid        = ($urandom % 4) != 0;
            id_rs           = RW'($urandom % 4);
            id_rt           = RW'($urandom % 4);
            id_uses_rt      = $urandom % 2;
            resume          = ($urandom % 5) == 0;
            #1;
            model_step(eo, eh, es);
            chk($sformatf("rnd%0d_outs", n), 32'(outs()), 32'(eo));
            chk($sformatf("rnd%0d_halted", n), 32'(halted), 32'(eh));
            chk($sformatf("rnd%0d_state", n), 32'(state_o), 32'(es));
            tick();
        end
        idle_in();

`ifdef PIPE_PERF_COUNTERS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ex_mem_read = 1; ex_rt = 2; id_rs = 2; id_valid = 1;
            tick(); idle_in(); tick();
        end
        for (int k = 0; k < 2; k++) begin
            ex_branch_en = 1; ex_branch_taken = 1; ex_pred_taken = 0;
            tick(); idle_in(); tick();
        end
        chk("perf_stall3", 32'(stall_count), 32'd3);
        chk("perf_flush2", 32'(flush_count), 32'd2);
        for (int k = 0; k < 16; k++) begin
            ex_mem_read = 1; ex_rt = 2; id_rs = 2; id_valid = 1;
            tick(); idle_in(); tick();
            ex_branch_en = 1; ex_branch_taken = 0; ex_pred_taken = 1;
            tick(); idle_in(); tick();
        end
        chk("perf_stall_sat", 32'(stall_count), 32'd15);
        chk("perf_flush_sat", 32'(flush_count), 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
